// File: rtl/chess_clock_pkg.sv
// Shared FSM encoding, BCD limits and BCD helper functions for the chess clock
// player timers.
package chess_clock_pkg;

    typedef enum logic [1:0] {
        READY   = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        TIMEOUT = 2'd3
    } state_t;

    localparam logic [7:0] SEC_MAX = 8'h59;
    localparam logic [7:0] MIN_MAX = 8'h99;

    // Force each nibble into 0..9, then cap the two-digit value at max_v.
    function automatic logic [7:0] bcd_clamp(input logic [7:0] v, input logic [7:0] max_v);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = (v[7:4] > 4'd9) ? 4'd9 : v[7:4];
        lo = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
        if ({hi, lo} > max_v) begin
            return max_v;
        end
        return {hi, lo};
    endfunction

    function automatic logic [6:0] bcd_to_bin(input logic [7:0] v);
        return {3'b000, v[7:4]} * 7'd10 + {3'b000, v[3:0]};
    endfunction

    function automatic logic [7:0] bin_to_bcd(input logic [6:0] b);
        return {4'(b / 7'd10), 4'(b % 7'd10)};
    endfunction

endpackage

// File: rtl/bcd_down_counter.sv
// Two-digit BCD down counter with borrow chaining; wraps to MAX on borrow
// unless the hold input (underflow of the whole chain) blocks the update.
module bcd_down_counter #(
    parameter logic [7:0] MAX = 8'h59
) (
    input  logic       clk,
    input  logic       load,
    input  logic [7:0] load_value,
    input  logic       hold,
    input  logic       borrow_in,
    output logic [7:0] value,
    output logic       borrow_out
);

    assign borrow_out = borrow_in && (value == 8'h00);

    always_ff @(posedge clk) begin
        if (load) begin
            value <= load_value;
        end else if (borrow_in && !hold) begin
            if (value == 8'h00) begin
                value <= MAX;
            end else if (value[3:0] == 4'h0) begin
                value <= {value[7:4] - 4'd1, 4'h9};
            end else begin
                value <= {value[7:4], value[3:0] - 4'd1};
            end
        end
    end

endmodule

// File: rtl/player_timer.sv
// Per-player BCD mm:ss countdown with READY/RUN/PAUSE/TIMEOUT control.
// Define PLAYER_TIMER_INCREMENT_EN to add INC_SEC each time the turn is handed over.
module player_timer #(
    parameter int         TICK_DIV    = 100,
    parameter logic [7:0] DEFAULT_MIN = 8'h05,
    parameter logic [7:0] DEFAULT_SEC = 8'h00
`ifdef PLAYER_TIMER_INCREMENT_EN
    , parameter logic [7:0] INC_SEC   = 8'h02
`endif
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       CE,
    input  logic       ENABLE,
    input  logic       LOAD,
    input  logic [7:0] PRESET_MIN,
    input  logic [7:0] PRESET_SEC,
    output logic [7:0] MIN_BCD,
    output logic [7:0] SEC_BCD,
    output logic       RUNNING,
    output logic       END
);
    import chess_clock_pkg::*;

    localparam int SUB_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TICK_DIV - 1);
    localparam logic [1:0] ST_READY   = READY;
    localparam logic [1:0] ST_RUN     = RUN;
    localparam logic [1:0] ST_PAUSE   = PAUSE;
    localparam logic [1:0] ST_TIMEOUT = TIMEOUT;
    localparam logic [7:0] DEF_MIN = bcd_clamp(DEFAULT_MIN, MIN_MAX);
    localparam logic [7:0] DEF_SEC = bcd_clamp(DEFAULT_SEC, SEC_MAX);

    logic [1:0]       state, state_next;
    logic [SUB_W-1:0] sub, sub_next;
    logic [7:0]       min_v, sec_v, pre_min, pre_sec;
    logic [7:0]       ld_min, ld_sec, inc_min, inc_sec;
    logic             ld, inc_apply, advance, sec_tick, last_second;
    logic             sec_borrow, underflow;

    assign pre_min     = bcd_clamp(PRESET_MIN, MIN_MAX);
    assign pre_sec     = bcd_clamp(PRESET_SEC, SEC_MAX);
    assign advance     = (state == ST_RUN) && ENABLE && CE && !inc_apply;
    assign sec_tick    = advance && (sub == SUB_LAST);
    assign last_second = sec_tick && (min_v == 8'h00) && (sec_v == 8'h01);
    assign ld          = CLR || LOAD || inc_apply;

    always_comb begin
        ld_min = inc_min;
        ld_sec = inc_sec;
        if (CLR) begin
            ld_min = DEF_MIN;
            ld_sec = DEF_SEC;
        end else if (LOAD) begin
            ld_min = pre_min;
            ld_sec = pre_sec;
        end
    end

    // A borrow out of the minutes digit means 00:00 was asked to go lower: hold both.
    bcd_down_counter #(.MAX(SEC_MAX)) u_sec (
        .clk(CLK), .load(ld), .load_value(ld_sec), .hold(underflow),
        .borrow_in(sec_tick), .value(sec_v), .borrow_out(sec_borrow)
    );

    bcd_down_counter #(.MAX(MIN_MAX)) u_min (
        .clk(CLK), .load(ld), .load_value(ld_min), .hold(underflow),
        .borrow_in(sec_borrow), .value(min_v), .borrow_out(underflow)
    );

    always_comb begin
        state_next = state;
        sub_next   = sub;
        if (LOAD) begin
            sub_next   = '0;
            state_next = (pre_min == 8'h00 && pre_sec == 8'h00) ? ST_TIMEOUT : ST_READY;
        end else begin
            case (state)
                ST_READY, ST_PAUSE: begin
                    if (ENABLE) state_next = ST_RUN;
                end
                ST_RUN: begin
                    if (!ENABLE) begin
                        state_next = ST_PAUSE;
                    end else if (advance) begin
                        sub_next = (sub == SUB_LAST) ? '0 : sub + SUB_W'(1);
                        if (last_second) state_next = ST_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state   <= ST_READY;
            sub     <= '0;
            RUNNING <= 1'b0;
            END     <= 1'b0;
        end else begin
            state   <= state_next;
            sub     <= sub_next;
            RUNNING <= (state_next == ST_RUN);
            END     <= (state_next == ST_TIMEOUT);
        end
    end

`ifdef PLAYER_TIMER_INCREMENT_EN
    localparam logic [7:0]  INC_CL    = bcd_clamp(INC_SEC, SEC_MAX);
    localparam logic [12:0] TOTAL_MAX = 13'd5999;

    logic        ena_q, inc_pend;
    logic [12:0] total;

    // The fall is registered first, so the bonus lands one cycle after it is seen.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            ena_q    <= 1'b0;
            inc_pend <= 1'b0;
        end else begin
            ena_q    <= ENABLE;
            inc_pend <= ena_q && !ENABLE && !LOAD && (state != ST_TIMEOUT);
        end
    end

    assign inc_apply = inc_pend && !CLR && !LOAD && (state != ST_TIMEOUT);

    always_comb begin
        total = 13'(bcd_to_bin(min_v)) * 13'd60 + 13'(bcd_to_bin(sec_v)) + 13'(bcd_to_bin(INC_CL));
        if (total > TOTAL_MAX) total = TOTAL_MAX;
        inc_min = bin_to_bcd(7'(total / 13'd60));
        inc_sec = bin_to_bcd(7'(total % 13'd60));
    end
`else
    assign inc_apply = 1'b0;
    assign inc_min   = min_v;
    assign inc_sec   = sec_v;
`endif

    assign MIN_BCD = min_v;
    assign SEC_BCD = sec_v;

endmodule
